// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int BYTE_CNT_W = 2;
  localparam int LEN_W = 16;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted data bytes MSB-first into 32-bit words and keeps the running XOR.
// Latency: wordReady pulses 1 cycle after the 4th byte; no backpressure of its own.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        clear,
  input  logic        byteEn,
  input  logic [7:0]  inByte,
  output logic        lastByte,
  output logic [31:0] wordOut,
  output logic [7:0]  xorAcc,
  output logic        wordReady
);

  // Only three bytes need holding; the fourth arrives with the completing transfer.
  logic [23:0]           shiftReg;
  logic [BYTE_CNT_W-1:0] byteCnt;

  assign lastByte = byteEn && (byteCnt == '1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shiftReg  <= '0;
      byteCnt   <= '0;
      xorAcc    <= '0;
      wordOut   <= '0;
      wordReady <= 1'b0;
    end else begin
      wordReady <= lastByte;
      if (clear) begin
        shiftReg <= '0;
        byteCnt  <= '0;
        xorAcc   <= '0;
      end else if (byteEn) begin
        shiftReg <= {shiftReg[15:0], inByte};
        byteCnt  <= byteCnt + 1'b1;
        xorAcc   <= xorAcc ^ inByte;
        // Separate output register so write data holds while the next word shifts in.
        if (byteCnt == '1) begin
          wordOut <= {shiftReg, inByte};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing big-endian words to instruction memory from address 0.
// Latency: write 1 cycle after a word's 4th byte; Done/Error 1 cycle after CSUM or bad length.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [7:0]        InByte,
  input  logic              InValid,
  output logic              InReady,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWriteData,
  output logic              MemWrite,
  output logic              CpuReset,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   WordCount
);

  localparam logic [LEN_W:0] MAX_LEN = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_t            state;
  state_t            nextState;
  logic [7:0]        lenHi;
  logic [LEN_W-1:0]  lenReg;
  logic [LEN_W-1:0]  frameLen;
  logic [LEN_W:0]    nextCount;
  logic              accept;
  logic              armStart;
  logic              lenBad;
  logic              lastWord;
  logic              dataEn;
  logic              asmLast;
  logic [7:0]        xorAcc;
  logic              wordReady;
  logic [31:0]       wordOut;
  logic [ADDR_W-1:0] memAddrReg;

  assign accept    = InValid && InReady;
  assign dataEn    = accept && (state == DATA);
  assign frameLen  = {lenHi, InByte};
  assign lenBad    = (frameLen == '0) || ({1'b0, frameLen} > MAX_LEN);
  assign nextCount = (LEN_W+1)'(WordCount) + (LEN_W+1)'(1);
  // WordCount lags the 4th byte by a cycle, so this word is number WordCount+1.
  assign lastWord  = (nextCount == {1'b0, lenReg});

  word_assembler u_word_assembler (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .clear     (armStart),
    .byteEn    (dataEn),
    .inByte    (InByte),
    .lastByte  (asmLast),
    .wordOut   (wordOut),
    .xorAcc    (xorAcc),
    .wordReady (wordReady)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    InReady   = 1'b0;
    Busy      = 1'b0;
    armStart  = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (Start) begin
          armStart  = 1'b1;
          nextState = SYNC;
        end
      end
      SYNC: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept && (InByte == SYNC_BYTE)) nextState = LEN_HI;
      end
      LEN_HI: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept) nextState = LEN_LO;
      end
      LEN_LO: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept) nextState = lenBad ? ERR : DATA;
      end
      DATA: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (asmLast && lastWord) nextState = CSUM;
      end
      CSUM: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept) nextState = (InByte == xorAcc) ? DONE : ERR;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lenHi      <= '0;
      lenReg     <= '0;
      WordCount  <= '0;
      memAddrReg <= '0;
    end else begin
      if (accept && (state == LEN_HI)) lenHi <= InByte;
      if (accept && (state == LEN_LO)) lenReg <= frameLen;
      if (armStart) begin
        WordCount <= '0;
      end else if (wordReady) begin
        WordCount <= WordCount + 1'b1;
      end
      if (asmLast) memAddrReg <= WordCount[ADDR_W-1:0];
    end
  end

  assign MemAddr      = memAddrReg;
  assign MemWriteData = wordOut;
  assign MemWrite     = wordReady;
  assign Done         = (state == DONE);
  assign Error        = (state == ERR);
  // Processor stays held from power-up until a frame has loaded cleanly.
  assign CpuReset     = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with ADDR_W=8.
module tb_imem_loader;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [7:0]  InByte;
  logic        InValid;
  logic        InReady;
  logic [7:0]  MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        CpuReset;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [8:0]  WordCount;

  int errors = 0;
  int checks = 0;
  logic [7:0]  wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .InByte       (InByte),
    .InValid      (InValid),
    .InReady      (InReady),
    .MemAddr      (MemAddr),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .CpuReset     (CpuReset),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error),
    .WordCount    (WordCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (MemWrite === 1'b1) begin
      wrAddrQ.push_back(MemAddr);
      wrDataQ.push_back(MemWriteData);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the byte transfers.
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    InByte  = b;
    InValid = 1'b1;
    while (InReady !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL sendByte timeout: InReady=%b required 1 for byte %h", InReady, b);
    end
    @(negedge Clk);
    InValid = 1'b0;
  endtask

  task automatic sendGap(input logic [7:0] b);
    sendByte(b);
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulseStart();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic clearLog();
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checks++;
    if ({CpuReset, InReady, MemWrite, Busy, Done, Error} !== 6'b100000) begin
      errors++;
      $display("FAIL %s ctrl: {CpuReset,InReady,MemWrite,Busy,Done,Error}=%b required 100000",
               tag, {CpuReset, InReady, MemWrite, Busy, Done, Error});
    end
    checks++;
    if ({MemAddr, MemWriteData, WordCount} !== 49'd0) begin
      errors++;
      $display("FAIL %s data: MemAddr=%h MemWriteData=%h WordCount=%0d required all 0",
               tag, MemAddr, MemWriteData, WordCount);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #3;
    checkResetOutputs("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if ({Busy, InReady, CpuReset, Done} !== 4'b0010) begin
      errors++;
      $display("FAIL idle_after_reset: {Busy,InReady,CpuReset,Done}=%b required 0010",
               {Busy, InReady, CpuReset, Done});
    end
  endtask

  task automatic test_good_load();
    clearLog();
    pulseStart();
    checks++;
    if ({Busy, InReady, CpuReset} !== 3'b111) begin
      errors++;
      $display("FAIL arm: {Busy,InReady,CpuReset}=%b required 111", {Busy, InReady, CpuReset});
    end
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h20); sendByte(8'h08); sendByte(8'h00); sendByte(8'h05);
    checks++;
    if ({MemWrite, MemAddr, MemWriteData} !== {1'b1, 8'd0, 32'h20080005}) begin
      errors++;
      $display("FAIL write0: MemWrite=%b MemAddr=%h data=%h required 1 00 20080005",
               MemWrite, MemAddr, MemWriteData);
    end
    sendByte(8'hAC); sendByte(8'h09); sendByte(8'h00); sendByte(8'h00);
    checks++;
    if ({MemWrite, MemAddr, MemWriteData, Busy} !== {1'b1, 8'd1, 32'hAC090000, 1'b1}) begin
      errors++;
      $display("FAIL write1: MemWrite=%b MemAddr=%h data=%h Busy=%b required 1 01 ac090000 1",
               MemWrite, MemAddr, MemWriteData, Busy);
    end
    sendByte(8'h88);
    #1;
    checks++;
    if ({Done, Error, CpuReset, Busy, InReady, WordCount} !== {5'b10000, 9'd2}) begin
      errors++;
      $display("FAIL good_status: {Done,Error,CpuReset,Busy,InReady}=%b WordCount=%0d required 10000 2",
               {Done, Error, CpuReset, Busy, InReady}, WordCount);
    end
    checks++;
    if ({MemWrite, MemAddr, MemWriteData} !== {1'b0, 8'd1, 32'hAC090000}) begin
      errors++;
      $display("FAIL hold: MemWrite=%b MemAddr=%h data=%h required 0 01 ac090000",
               MemWrite, MemAddr, MemWriteData);
    end
    checks++;
    if (wrAddrQ.size() != 2 || wrAddrQ[0] !== 8'd0 || wrDataQ[0] !== 32'h20080005 ||
        wrAddrQ[1] !== 8'd1 || wrDataQ[1] !== 32'hAC090000) begin
      errors++;
      $display("FAIL good_writes: count=%0d required 2 (00:20080005, 01:ac090000)", wrAddrQ.size());
    end
  endtask

  task automatic test_garbage_sync();
    clearLog();
    pulseStart();
    checks++;
    if ({Done, Error, CpuReset, WordCount} !== {3'b001, 9'd0}) begin
      errors++;
      $display("FAIL restart_clear: {Done,Error,CpuReset}=%b WordCount=%0d required 001 0",
               {Done, Error, CpuReset}, WordCount);
    end
    sendByte(8'h00); sendByte(8'hFF);
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h12); sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
    sendByte(8'h08);
    #1;
    checks++;
    if ({Done, Error, CpuReset, WordCount} !== {3'b100, 9'd1}) begin
      errors++;
      $display("FAIL garbage_status: {Done,Error,CpuReset}=%b WordCount=%0d required 100 1",
               {Done, Error, CpuReset}, WordCount);
    end
    checks++;
    if (wrAddrQ.size() != 1 || wrAddrQ[0] !== 8'd0 || wrDataQ[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL garbage_writes: count=%0d required 1 (00:12345678)", wrAddrQ.size());
    end
  endtask

  task automatic test_bad_csum();
    clearLog();
    pulseStart();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hDE); sendByte(8'hAD); sendByte(8'hBE); sendByte(8'hEF);
    sendByte(8'h23);
    #1;
    checks++;
    if ({Done, Error, CpuReset, Busy, WordCount} !== {4'b0110, 9'd1}) begin
      errors++;
      $display("FAIL bad_csum_status: {Done,Error,CpuReset,Busy}=%b WordCount=%0d required 0110 1",
               {Done, Error, CpuReset, Busy}, WordCount);
    end
    checks++;
    if (wrAddrQ.size() != 1 || wrDataQ[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bad_csum_write: count=%0d required 1 (00:deadbeef)", wrAddrQ.size());
    end
  endtask

  task automatic test_bad_len();
    clearLog();
    pulseStart();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
    checks++;
    if ({Error, Done, CpuReset, Busy} !== 4'b1010) begin
      errors++;
      $display("FAIL len0: {Error,Done,CpuReset,Busy}=%b required 1010", {Error, Done, CpuReset, Busy});
    end
    pulseStart();
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h01);
    checks++;
    if ({Error, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL len257: {Error,Busy}=%b required 10", {Error, Busy});
    end
    pulseStart();
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
    checks++;
    if ({Error, Busy, InReady} !== 3'b011) begin
      errors++;
      $display("FAIL len256: {Error,Busy,InReady}=%b required 011", {Error, Busy, InReady});
    end
    #1;
    checks++;
    if (wrAddrQ.size() != 0) begin
      errors++;
      $display("FAIL bad_len_writes: count=%0d required 0", wrAddrQ.size());
    end
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_stall_reset();
    clearLog();
    pulseStart();
    sendGap(8'hA5); sendGap(8'h00); sendGap(8'h01);
    sendGap(8'h01); sendGap(8'h02);
    checks++;
    if ({MemWrite, Busy, InReady, Done} !== 4'b0110) begin
      errors++;
      $display("FAIL stall_mid: {MemWrite,Busy,InReady,Done}=%b required 0110",
               {MemWrite, Busy, InReady, Done});
    end
    sendGap(8'h03); sendGap(8'h04); sendGap(8'h04);
    checks++;
    if ({Done, CpuReset, WordCount} !== {2'b10, 9'd1}) begin
      errors++;
      $display("FAIL stall_status: {Done,CpuReset}=%b WordCount=%0d required 10 1",
               {Done, CpuReset}, WordCount);
    end
    checks++;
    if (wrAddrQ.size() != 1 || wrDataQ[0] !== 32'h01020304) begin
      errors++;
      $display("FAIL stall_write: count=%0d required 1 (00:01020304)", wrAddrQ.size());
    end
    clearLog();
    pulseStart();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'h11); sendByte(8'h22);
    Reset_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({wrAddrQ.size() != 0, Busy, CpuReset} !== 3'b001) begin
      errors++;
      $display("FAIL abort_after: writes=%0d Busy=%b CpuReset=%b required 0 0 1",
               wrAddrQ.size(), Busy, CpuReset);
    end
  endtask

  task automatic test_start_ignored();
    clearLog();
    pulseStart();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    sendByte(8'h55);
    pulseStart();
    checks++;
    if ({Busy, InReady, WordCount} !== {2'b11, 9'd1}) begin
      errors++;
      $display("FAIL start_busy: {Busy,InReady}=%b WordCount=%0d required 11 1",
               {Busy, InReady}, WordCount);
    end
    sendByte(8'h66); sendByte(8'h77); sendByte(8'h88);
    sendByte(8'h88);
    #1;
    checks++;
    if ({Done, Error, WordCount} !== {2'b10, 9'd2}) begin
      errors++;
      $display("FAIL start_ign_status: {Done,Error}=%b WordCount=%0d required 10 2",
               {Done, Error}, WordCount);
    end
    checks++;
    if (wrAddrQ.size() != 2 || wrDataQ[0] !== 32'h11223344 || wrAddrQ[1] !== 8'd1 ||
        wrDataQ[1] !== 32'h55667788) begin
      errors++;
      $display("FAIL start_ign_writes: count=%0d required 2 (00:11223344, 01:55667788)",
               wrAddrQ.size());
    end
  endtask

  task automatic test_start_with_byte();
    clearLog();
    Start   = 1'b1;
    InValid = 1'b1;
    InByte  = 8'hA5;
    @(negedge Clk);
    Start   = 1'b0;
    InValid = 1'b0;
    sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC); sendByte(8'hDD);
    sendByte(8'h00);
    #1;
    checks++;
    if ({Busy, Done, Error, wrAddrQ.size() != 0} !== 4'b1000) begin
      errors++;
      $display("FAIL start_byte_dropped: {Busy,Done,Error}=%b writes=%0d required 100 0",
               {Busy, Done, Error}, wrAddrQ.size());
    end
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC); sendByte(8'hDD);
    sendByte(8'h00);
    #1;
    checks++;
    if ({Done, CpuReset} !== 2'b10 || wrAddrQ.size() != 1 || wrDataQ[0] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL start_byte_reload: {Done,CpuReset}=%b writes=%0d required 10 1 (aabbccdd)",
               {Done, CpuReset}, wrAddrQ.size());
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    Start   = 1'b0;
    InValid = 1'b0;
    InByte  = 8'h00;
    test_reset();
    test_good_load();
    test_garbage_sync();
    test_bad_csum();
    test_bad_len();
    test_stall_reset();
    test_start_ignored();
    test_start_with_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It accepts a framed byte stream over a valid/ready interface, packs bytes into 32-bit big-endian instruction words and writes them to sequential instruction-memory addresses starting at 0. It verifies an XOR checksum and holds the processor in reset until a frame loads cleanly. It is the write side of the instruction memory that the fetch unit reads.

## Interface
- `ADDR_W`, 8, instruction-memory word-address width; maximum frame length is 2^ADDR_W words.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset_n`  in  1  reset, asynchronous and active-low.
- `Start`  in  1  one-cycle request to arm a load; honoured only in IDLE, DONE or ERR.
- `InByte`  in  8  stream byte.
- `InValid`  in  1  `InByte` is valid.
- `InReady`  out  1  loader accepts a byte this cycle; a byte transfers when `InValid && InReady`.
- `MemAddr`  out  ADDR_W  word address of the current write.
- `MemWriteData`  out  32  instruction word to write.
- `MemWrite`  out  1  one-cycle write strobe.
- `CpuReset`  out  1  active-high hold for the processor `Reset`.
- `Busy`  out  1  a load is in progress (SYNC through CSUM).
- `Done`  out  1  last frame loaded and checksum matched; level signal.
- `Error`  out  1  last frame failed; level signal.
- `WordCount`  out  ADDR_W+1  number of words written in the current or last frame.

## Operation
- Frame format: `SYNC_BYTE`, LEN_HI, LEN_LO, 4·N data bytes (MSB first per word), CSUM.
  - N = {LEN_HI, LEN_LO} is the word count.
  - CSUM is the XOR of all 4·N data bytes.
- States: IDLE, SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + `Start` → SYNC. The same transition:
  - clears `WordCount`, the byte counter and the XOR accumulator;
  - clears `Done` and `Error`;
  - sets `CpuReset` to 1.
- `Start` in any other state is ignored.
- `InReady` is 1 exactly in SYNC, LEN_HI, LEN_LO, DATA and CSUM.
- SYNC: an accepted byte equal to `SYNC_BYTE` moves to LEN_HI. Any other byte is discarded and the state stays SYNC.
- LEN_HI → LEN_LO on an accepted byte.
- LEN_LO: on an accepted byte, N is formed.
  - N = 0 or N > 2^ADDR_W → ERR.
  - Otherwise → DATA.
  - N is held in a 16-bit register.
- DATA:
  - Each accepted byte shifts into the word register (`word = {word[23:0], byte}`) and is XORed into the accumulator.
  - The 4th byte of a word triggers a write on the next cycle: `MemWrite`=1, `MemAddr`=`WordCount`[ADDR_W-1:0], `MemWriteData`=the assembled word.
  - `WordCount` increments in the same cycle as that write.
  - When the 4th byte of word N is accepted, the state moves to CSUM. The final write occurs during the first CSUM cycle.
- CSUM: on an accepted byte, a match with the accumulator → DONE (`Done`=1, `CpuReset`=0). A mismatch → ERR (`Error`=1, `CpuReset` stays 1).
- `MemWriteData` and `MemAddr` hold their last values when `MemWrite`=0.
- A partial frame never completes a write.
- Loaded words stay in memory after ERR. `CpuReset` stays 1 until a later frame succeeds.
- Address wrap is impossible: the length check bounds the address at 2^ADDR_W−1.

## Timing
- Reset values:
  - state=IDLE;
  - `CpuReset`=1, `InReady`=0, `MemWrite`=0, `Busy`=0, `Done`=0, `Error`=0;
  - `MemAddr`=0, `MemWriteData`=0, `WordCount`=0.
- The processor is therefore held from power-up until the first good load.
- Throughput: one byte per cycle. `InReady` never drops inside a frame, so back-to-back bytes are always accepted.
- Write latency: `MemWrite` rises 1 cycle after the 4th byte of a word is accepted and lasts exactly 1 cycle.
- `Done` or `Error` rises 1 cycle after the CSUM byte, or the bad LEN_LO byte, is accepted. `CpuReset` falls in that same cycle.
- `InValid` low simply stalls the load. No timeout.
- `Reset_n` asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Any pending write strobe is dropped and the partial frame is abandoned.
- `Start` arriving in the same cycle as a byte in DONE/ERR: the transition to SYNC occurs and the byte is not accepted (`InReady`=0 that cycle).

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum;
  - the default `SYNC_BYTE`;
  - byte-count width constants (2-bit byte-in-word counter, 16-bit length).
- Sub-module `word_assembler` contains:
  - the shift register;
  - the 2-bit byte counter;
  - the XOR accumulator;
  - a registered `word_ready` pulse that drives `MemWrite`.
- The top level holds the FSM, the length check, `WordCount` and the status outputs.

## Test plan
- Good load, 2 words: `Start`, then A5 00 02 20 08 00 05 AC 09 00 00 CSUM=(20^08^00^05^AC^09^00^00)=88.
  - Writes 32'h20080005 at addr 0 and 32'hAC090000 at addr 1.
  - `Done`=1, `CpuReset`=0, `WordCount`=2.
- Garbage before sync: bytes 00 FF A5 followed by a valid 1-word frame. The leading bytes are discarded and exactly one write occurs at addr 0.
- Bad checksum: a valid 1-word frame with CSUM off by 1.
  - The word is written.
  - `Error`=1, `CpuReset` stays 1, `Done`=0.
- Bad length: A5 00 00 → `Error`=1 one cycle after the third byte, no `MemWrite`. Likewise A5 01 01 with `ADDR_W`=8 (N=257) → `Error`=1.
- Stall and reset: a 1-word frame with `InValid` gaps of 3 cycles still loads correctly. A second frame aborted by `Reset_n` low after 2 data bytes ends with all outputs at reset values and no write strobe.
- `Start` ignored while `Busy`: `Start` pulsed during DATA causes no state change and no counter clear.
